// File: rtl/psu_tach_monitor.sv
// PSU1 fan tachometer monitor: counts synchronised tach edges per Strobe16ms window
// and debounces the low/high classifications into the PSU1 fault flags.
module psu_tach_monitor #(
    parameter int WINDOW_STROBES = 64,
    parameter int LOW_LIMIT      = 8,
    parameter int HIGH_LIMIT     = 200,
    parameter int FAIL_COUNT     = 3
) (
    input  logic       SlowClock,
    input  logic       Reset,
    input  logic       Strobe16ms,
    input  logic       Enable,
    input  logic       PSU1_Tach,
    output logic       PSU1_Tach_Low,
    output logic       PSU1_Tach_High,
    output logic [7:0] TachCount,
    output logic       WindowDone
);
    localparam logic [7:0] LAST_STROBE = 8'(WINDOW_STROBES - 1);
    localparam logic [7:0] LOW_LIM     = 8'(LOW_LIMIT);
    localparam logic [7:0] HIGH_LIM    = 8'(HIGH_LIMIT);
    localparam logic [2:0] FAIL_RUN    = 3'(FAIL_COUNT);

    typedef enum logic [1:0] {ST_OK, ST_SUSPECT, ST_FAIL, ST_RECOVER} filt_state_t;

    logic       r_sync_p0;
    logic       r_sync_p1;
    logic       r_sync_p2;
    logic       w_rise;
    logic [7:0] r_edge_cnt;
    logic [7:0] r_win_cnt;
    logic [7:0] r_tach_count;
    logic [7:0] w_edge_next;
    logic       r_done;
    logic       w_close;
    logic [1:0] w_match;

    function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic inc);
        return (inc && (v != 8'hFF)) ? v + 8'd1 : v;
    endfunction

    // Stage p0/p1: two-flop synchroniser; p2: edge-detect history
    always_ff @(posedge SlowClock) begin
        if (Reset) begin
            r_sync_p0 <= 1'b0;
            r_sync_p1 <= 1'b0;
            r_sync_p2 <= 1'b0;
        end else begin
            r_sync_p0 <= PSU1_Tach;
            r_sync_p1 <= r_sync_p0;
            r_sync_p2 <= r_sync_p1;
        end
    end

    assign w_rise      = r_sync_p1 & ~r_sync_p2;
    assign w_edge_next = sat_inc(r_edge_cnt, w_rise);
    assign w_close     = Strobe16ms && (r_win_cnt == LAST_STROBE);

    // Window stage: an edge seen on the closing cycle still lands in the closing window
    always_ff @(posedge SlowClock) begin
        if (Reset || !Enable) begin
            r_edge_cnt   <= 8'd0;
            r_win_cnt    <= 8'd0;
            r_tach_count <= 8'd0;
            r_done       <= 1'b0;
        end else begin
            r_done <= w_close;
            if (w_close) begin
                r_tach_count <= w_edge_next;
                r_edge_cnt   <= 8'd0;
                r_win_cnt    <= 8'd0;
            end else begin
                r_edge_cnt <= w_edge_next;
                if (Strobe16ms) begin
                    r_win_cnt <= r_win_cnt + 8'd1;
                end
            end
        end
    end

    // Classification: bit 0 feeds the low filter, bit 1 the high filter
    assign w_match = {(r_tach_count > HIGH_LIM), (r_tach_count < LOW_LIM)};

    for (genvar g = 0; g < 2; g++) begin : g_filt
        filt_state_t r_state;
        logic [2:0]  r_run;
        logic        r_flag;
        logic [2:0]  w_run_inc;

        assign w_run_inc = r_run + 3'd1;

        // Filter stage: advances only on the cycle after a window closes
        always_ff @(posedge SlowClock) begin
            if (Reset || !Enable) begin
                r_state <= ST_OK;
                r_run   <= 3'd0;
                r_flag  <= 1'b0;
            end else if (r_done) begin
                case (r_state)
                    ST_OK: begin
                        if (w_match[g]) begin
                            if (FAIL_RUN == 3'd1) begin
                                r_state <= ST_FAIL;
                                r_run   <= 3'd0;
                                r_flag  <= 1'b1;
                            end else begin
                                r_state <= ST_SUSPECT;
                                r_run   <= 3'd1;
                            end
                        end
                    end
                    ST_SUSPECT: begin
                        if (!w_match[g]) begin
                            r_state <= ST_OK;
                            r_run   <= 3'd0;
                        end else if (w_run_inc == FAIL_RUN) begin
                            r_state <= ST_FAIL;
                            r_run   <= 3'd0;
                            r_flag  <= 1'b1;
                        end else begin
                            r_run <= w_run_inc;
                        end
                    end
                    ST_FAIL: begin
                        if (!w_match[g]) begin
                            if (FAIL_RUN == 3'd1) begin
                                r_state <= ST_OK;
                                r_run   <= 3'd0;
                                r_flag  <= 1'b0;
                            end else begin
                                r_state <= ST_RECOVER;
                                r_run   <= 3'd1;
                            end
                        end
                    end
                    ST_RECOVER: begin
                        if (w_match[g]) begin
                            r_state <= ST_FAIL;
                            r_run   <= 3'd0;
                        end else if (w_run_inc == FAIL_RUN) begin
                            r_state <= ST_OK;
                            r_run   <= 3'd0;
                            r_flag  <= 1'b0;
                        end else begin
                            r_run <= w_run_inc;
                        end
                    end
                    default: begin
                        r_state <= ST_OK;
                        r_run   <= 3'd0;
                        r_flag  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign PSU1_Tach_Low  = g_filt[0].r_flag;
    assign PSU1_Tach_High = g_filt[1].r_flag;
    assign TachCount      = r_tach_count;
    assign WindowDone     = r_done;
endmodule

// File: tb/tb_psu_tach_monitor.sv
// Self-checking bench for psu_tach_monitor: scenario tasks compared against a
// window-level reference model built from edge counts and consecutive-window streaks.
module tb_psu_tach_monitor;
    localparam int WS    = 4;
    localparam int LOWL  = 8;
    localparam int HIGHL = 200;
    localparam int FC    = 3;
    localparam int WAIT_LIMIT = 4000;

    logic       SlowClock = 1'b0;
    logic       Reset;
    logic       Strobe16ms;
    logic       Enable;
    logic       PSU1_Tach;
    logic       PSU1_Tach_Low;
    logic       PSU1_Tach_High;
    logic [7:0] TachCount;
    logic       WindowDone;

    int checks = 0;
    int errors = 0;

    psu_tach_monitor #(
        .WINDOW_STROBES(WS),
        .LOW_LIMIT(LOWL),
        .HIGH_LIMIT(HIGHL),
        .FAIL_COUNT(FC)
    ) dut (
        .SlowClock(SlowClock),
        .Reset(Reset),
        .Strobe16ms(Strobe16ms),
        .Enable(Enable),
        .PSU1_Tach(PSU1_Tach),
        .PSU1_Tach_Low(PSU1_Tach_Low),
        .PSU1_Tach_High(PSU1_Tach_High),
        .TachCount(TachCount),
        .WindowDone(WindowDone)
    );

    always #5 SlowClock = ~SlowClock;

    // Stimulus generator state
    int   strobe_per   = 300;
    int   strobe_ctr   = 0;
    int   strobes_sent = 0;
    int   tach_per     = 0;
    logic tach_hold    = 1'b0;
    int   tach_phase   = 0;

    // Reference model: a tach edge is counted three clocks after it is sampled;
    // flags follow FC-long runs of matching / non-matching windows.
    logic [2:0] m_hist = 3'b000;
    int         m_edges = 0;
    int         m_win = 0;
    logic [7:0] m_count = 8'd0;
    bit         m_done = 1'b0;
    bit         m_low = 1'b0;
    bit         m_high = 1'b0;
    int         m_lo_hit = 0, m_lo_miss = 0, m_hi_hit = 0, m_hi_miss = 0;

    always @(posedge SlowClock) begin
        bit rise;
        rise = m_hist[1] && !m_hist[2];
        if (Reset) begin
            m_hist = 3'b000; m_edges = 0; m_win = 0; m_count = 8'd0; m_done = 1'b0;
            m_low = 1'b0; m_high = 1'b0;
            m_lo_hit = 0; m_lo_miss = 0; m_hi_hit = 0; m_hi_miss = 0;
        end else begin
            m_hist = {m_hist[1:0], PSU1_Tach};
            if (!Enable) begin
                m_edges = 0; m_win = 0; m_count = 8'd0; m_done = 1'b0;
                m_low = 1'b0; m_high = 1'b0;
                m_lo_hit = 0; m_lo_miss = 0; m_hi_hit = 0; m_hi_miss = 0;
            end else begin
                if (m_done) begin
                    if (m_count < LOWL) begin m_lo_hit++; m_lo_miss = 0; end
                    else begin m_lo_miss++; m_lo_hit = 0; end
                    if (m_count > HIGHL) begin m_hi_hit++; m_hi_miss = 0; end
                    else begin m_hi_miss++; m_hi_hit = 0; end
                    if (!m_low && m_lo_hit >= FC) m_low = 1'b1;
                    else if (m_low && m_lo_miss >= FC) m_low = 1'b0;
                    if (!m_high && m_hi_hit >= FC) m_high = 1'b1;
                    else if (m_high && m_hi_miss >= FC) m_high = 1'b0;
                end
                if (rise && m_edges < 255) m_edges++;
                m_done = 1'b0;
                if (Strobe16ms) begin
                    m_win++;
                    if (m_win == WS) begin
                        m_count = 8'(m_edges);
                        m_edges = 0;
                        m_win = 0;
                        m_done = 1'b1;
                    end
                end
            end
        end
    end

    task automatic step();
        @(negedge SlowClock);
        if (strobe_ctr >= strobe_per - 1) begin
            Strobe16ms = 1'b1;
            strobe_ctr = 0;
        end else begin
            Strobe16ms = 1'b0;
            strobe_ctr++;
        end
        if (Strobe16ms) strobes_sent++;
        if (tach_per == 0) begin
            PSU1_Tach = tach_hold;
        end else begin
            tach_phase = (tach_phase + 1 >= tach_per) ? 0 : tach_phase + 1;
            PSU1_Tach = (tach_phase < tach_per / 2);
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < WAIT_LIMIT; i++) begin
            step();
            if (m_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic restart();
        Enable = 1'b0;
        repeat (5) step();
        Enable = 1'b1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Enable = 1'b1; tach_per = 10;
        repeat (6) step();
        checks++; if (PSU1_Tach_Low !== 1'b0) begin errors++; $display("FAIL reset_low got %b want 0", PSU1_Tach_Low); end
        checks++; if (PSU1_Tach_High !== 1'b0) begin errors++; $display("FAIL reset_high got %b want 0", PSU1_Tach_High); end
        checks++; if (TachCount !== 8'd0) begin errors++; $display("FAIL reset_count got %0d want 0", TachCount); end
        checks++; if (WindowDone !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", WindowDone); end
        Reset = 1'b0;
    endtask

    task automatic test_normal();
        bit ok;
        int s0, sampled;
        strobe_per = 524; tach_per = 160;
        restart();
        s0 = strobes_sent - int'(Strobe16ms);
        for (int k = 1; k <= 3; k++) begin
            wait_done(ok);
            checks++; if (!ok) begin errors++; $display("FAIL normal_timeout window %0d got none want WindowDone", k); end
            sampled = strobes_sent - s0 - int'(Strobe16ms);
            checks++; if (sampled != WS * k) begin errors++; $display("FAIL normal_strobes got %0d want %0d", sampled, WS * k); end
            checks++; if (WindowDone !== 1'b1) begin errors++; $display("FAIL normal_done got %b want 1", WindowDone); end
            checks++; if (TachCount !== m_count) begin errors++; $display("FAIL normal_count got %0d want %0d", TachCount, m_count); end
            checks++; if (TachCount < 8'd12 || TachCount > 8'd14) begin errors++; $display("FAIL normal_range got %0d want 13+-1", TachCount); end
            step();
            checks++; if (WindowDone !== 1'b0) begin errors++; $display("FAIL normal_pulse got %b want 0", WindowDone); end
            checks++; if ({PSU1_Tach_Low, PSU1_Tach_High} !== 2'b00) begin errors++; $display("FAIL normal_flags got %b%b want 00", PSU1_Tach_Low, PSU1_Tach_High); end
        end
        strobe_per = 300;
    endtask

    task automatic test_stall();
        bit ok;
        tach_per = 0; tach_hold = 1'b1;
        restart();
        for (int k = 1; k <= 3; k++) begin
            wait_done(ok);
            checks++; if (!ok) begin errors++; $display("FAIL stall_timeout window %0d got none want WindowDone", k); end
            checks++; if (TachCount !== 8'd0 || m_count !== 8'd0) begin errors++; $display("FAIL stall_count got %0d want 0", TachCount); end
            checks++; if (PSU1_Tach_Low !== 1'b0) begin errors++; $display("FAIL stall_low_at_done got %b want 0", PSU1_Tach_Low); end
            step();
            checks++; if (PSU1_Tach_Low !== (k == 3) || PSU1_Tach_Low !== m_low) begin
                errors++; $display("FAIL stall_low window %0d got %b want %b", k, PSU1_Tach_Low, (k == 3)); end
        end
        tach_per = 60;
        for (int k = 1; k <= 3; k++) begin
            wait_done(ok);
            checks++; if (!ok) begin errors++; $display("FAIL recover_timeout window %0d got none want WindowDone", k); end
            step();
            checks++; if (PSU1_Tach_Low !== (k < 3) || PSU1_Tach_Low !== m_low) begin
                errors++; $display("FAIL recover_low window %0d got %b want %b", k, PSU1_Tach_Low, (k < 3)); end
        end
    endtask

    task automatic test_glitch();
        bit ok;
        int pers[9]  = '{0, 0, 60, 0, 0, 0, 60, 60, 0};
        bit lows[9]  = '{0, 0, 0, 0, 0, 1, 1, 1, 1};
        tach_per = 0; tach_hold = 1'b0;
        restart();
        for (int k = 0; k < 9; k++) begin
            tach_per = pers[k];
            wait_done(ok);
            checks++; if (!ok) begin errors++; $display("FAIL glitch_timeout window %0d got none want WindowDone", k); end
            checks++; if (TachCount !== m_count) begin errors++; $display("FAIL glitch_count got %0d want %0d", TachCount, m_count); end
            step();
            checks++; if (PSU1_Tach_Low !== lows[k] || PSU1_Tach_Low !== m_low) begin
                errors++; $display("FAIL glitch_low window %0d got %b want %b", k, PSU1_Tach_Low, lows[k]); end
        end
    endtask

    task automatic test_overspeed();
        bit ok;
        tach_per = 4;
        restart();
        for (int k = 1; k <= 3; k++) begin
            wait_done(ok);
            checks++; if (!ok) begin errors++; $display("FAIL over_timeout window %0d got none want WindowDone", k); end
            checks++; if (TachCount !== 8'd255 || m_count !== 8'd255) begin errors++; $display("FAIL over_count got %0d want 255", TachCount); end
            step();
            checks++; if (PSU1_Tach_High !== (k == 3) || PSU1_Tach_High !== m_high) begin
                errors++; $display("FAIL over_high window %0d got %b want %b", k, PSU1_Tach_High, (k == 3)); end
            checks++; if (PSU1_Tach_Low !== 1'b0) begin errors++; $display("FAIL over_low got %b want 0", PSU1_Tach_Low); end
        end
    endtask

    task automatic test_enable_drop();
        bit ok;
        int s0, sampled;
        repeat (200) step();
        Enable = 1'b0;
        step();
        checks++; if ({PSU1_Tach_Low, PSU1_Tach_High} !== 2'b00) begin errors++; $display("FAIL drop_flags got %b%b want 00", PSU1_Tach_Low, PSU1_Tach_High); end
        checks++; if (TachCount !== 8'd0) begin errors++; $display("FAIL drop_count got %0d want 0", TachCount); end
        repeat (3) step();
        Enable = 1'b1;
        s0 = strobes_sent - int'(Strobe16ms);
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL drop_timeout got none want WindowDone"); end
        sampled = strobes_sent - s0 - int'(Strobe16ms);
        checks++; if (sampled != WS || WindowDone !== 1'b1) begin errors++; $display("FAIL drop_first_window got %0d strobes want %0d", sampled, WS); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit hit;
        int s0, sampled;
        tach_per = 0; tach_hold = 1'b1;
        restart();
        repeat (3) wait_done(ok);
        step();
        tach_per = 20;
        hit = 1'b0;
        for (int i = 0; i < WAIT_LIMIT; i++) begin
            step();
            if (m_edges == 37) begin hit = 1'b1; break; end
        end
        checks++; if (!hit || PSU1_Tach_Low !== 1'b1) begin errors++; $display("FAIL rmid_setup got low=%b hit=%b want 1 1", PSU1_Tach_Low, hit); end
        Reset = 1'b1;
        Strobe16ms = 1'b1;
        step();
        Reset = 1'b0;
        checks++; if ({PSU1_Tach_Low, PSU1_Tach_High, WindowDone} !== 3'b000 || TachCount !== 8'd0) begin
            errors++; $display("FAIL rmid_outputs got %b%b%b %0d want 000 0", PSU1_Tach_Low, PSU1_Tach_High, WindowDone, TachCount); end
        s0 = strobes_sent - int'(Strobe16ms);
        wait_done(ok);
        sampled = strobes_sent - s0 - int'(Strobe16ms);
        checks++; if (!ok || sampled != WS) begin errors++; $display("FAIL rmid_window got %0d strobes want %0d", sampled, WS); end
        checks++; if (TachCount !== m_count) begin errors++; $display("FAIL rmid_count got %0d want %0d", TachCount, m_count); end
    endtask

    task automatic test_random();
        bit ok;
        int r;
        restart();
        for (int k = 0; k < 7; k++) begin
            r = $urandom_range(0, 3);
            if (r == 0) begin tach_per = 0; tach_hold = 1'($urandom_range(0, 1)); end
            else if (r == 1) tach_per = 4;
            else tach_per = $urandom_range(8, 300);
            wait_done(ok);
            checks++; if (!ok) begin errors++; $display("FAIL rand_timeout window %0d got none want WindowDone", k); end
            checks++; if (TachCount !== m_count) begin errors++; $display("FAIL rand_count per %0d got %0d want %0d", tach_per, TachCount, m_count); end
            step();
            checks++; if ({PSU1_Tach_Low, PSU1_Tach_High} !== {m_low, m_high}) begin
                errors++; $display("FAIL rand_flags got %b%b want %b%b", PSU1_Tach_Low, PSU1_Tach_High, m_low, m_high); end
        end
    endtask

    initial begin
        Reset = 1'b1; Enable = 1'b0; Strobe16ms = 1'b0; PSU1_Tach = 1'b0;
        test_reset();
        test_normal();
        test_stall();
        test_glitch();
        test_overspeed();
        test_enable_drop();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
